// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tile and its result-capture path.
package fir_pkg;

    localparam int BYTE_W = 8;
    localparam int DATA_W = 2 * BYTE_W;

    typedef enum logic [0:0] {
        S_LO = 1'b0,
        S_HI = 1'b1
    } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; storage is reset so the head output reads zero after reset.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             push_eff;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle;
    // the new word then lands in the slot the head vacates.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_eff) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_eff && !pop_eff) begin
                count <= count + CW'(1);
            end else if (pop_eff && !push_eff) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fir_result_capture.sv
// Reassembles the FIR core's lo/hi byte stream into words and queues them
// for a valid/ready consumer, flagging words lost to a full queue.
module fir_result_capture
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int BYTE_W = fir_pkg::BYTE_W,
    parameter int DEPTH  = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_vld,
    input  logic              byte_sync,
    output logic [DATA_W-1:0] word_out,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic [CW-1:0]     fifo_cnt,
    output logic              overflow,
    input  logic              clr_ovf
);

    cap_state_t        state_q;
    logic [BYTE_W-1:0] lo_q;
    logic              push_word;
    logic              word_drop;
    logic              fifo_full;
    logic              fifo_empty;

    // Byte assembly: a sync-marked byte in S_HI restarts the word with itself
    // as the new low byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            lo_q    <= '0;
        end else if (byte_vld) begin
            case (state_q)
                S_LO: begin
                    lo_q    <= byte_in;
                    state_q <= S_HI;
                end
                S_HI: begin
                    if (byte_sync) begin
                        lo_q <= byte_in;
                    end else begin
                        state_q <= S_LO;
                    end
                end
                default: state_q <= S_LO;
            endcase
        end
    end

    assign push_word = byte_vld && (state_q == S_HI) && !byte_sync;
    assign word_drop = push_word && fifo_full && !word_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (word_drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_word),
        .din   ({byte_in, lo_q}),
        .pop   (word_rdy),
        .dout  (word_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign word_vld = !fifo_empty;

endmodule

// File: tb/tb_fir_result_capture.sv
// Directed self-checking bench for fir_result_capture.
module tb_fir_result_capture;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_vld;
    logic        byte_sync;
    logic [15:0] word_out;
    logic        word_vld;
    logic        word_rdy;
    logic [2:0]  fifo_cnt;
    logic        overflow;
    logic        clr_ovf;

    int checks;
    int passed;

    fir_result_capture #(.DATA_W(16), .BYTE_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (byte_in),
        .byte_vld  (byte_vld),
        .byte_sync (byte_sync),
        .word_out  (word_out),
        .word_vld  (word_vld),
        .word_rdy  (word_rdy),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one byte for one edge; returns 1 time unit after that edge.
    task automatic send_byte(input logic [7:0] b, input logic s);
        byte_in   = b;
        byte_vld  = 1'b1;
        byte_sync = s;
        @(posedge clk);
        #1;
        byte_vld  = 1'b0;
        byte_sync = 1'b0;
    endtask

    task automatic pop_one();
        word_rdy = 1'b1;
        @(posedge clk);
        #1;
        word_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({word_vld, word_out, fifo_cnt, overflow} !== 21'd0)
            $display("FAIL reset_outputs: vld=%0b out=%h cnt=%0d ovf=%0b, required all 0",
                     word_vld, word_out, fifo_cnt, overflow);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send_byte(8'h34, 1'b0);
        checks++;
        if (word_vld !== 1'b0) $display("FAIL basic_lo_only: vld=%0b, required 0", word_vld);
        else passed++;
        send_byte(8'h12, 1'b0);
        checks++;
        if (word_vld !== 1'b1 || word_out !== 16'h1234 || fifo_cnt !== 3'd1)
            $display("FAIL basic_word: vld=%0b out=%h cnt=%0d, required 1 1234 1",
                     word_vld, word_out, fifo_cnt);
        else passed++;
        pop_one();
        checks++;
        if (word_vld !== 1'b0 || fifo_cnt !== 3'd0)
            $display("FAIL basic_pop: vld=%0b cnt=%0d, required 0 0", word_vld, fifo_cnt);
        else passed++;
    endtask

    task automatic test_resync();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b1);
        checks++;
        if (fifo_cnt !== 3'd0) $display("FAIL resync_no_push: cnt=%0d, required 0", fifo_cnt);
        else passed++;
        send_byte(8'h66, 1'b0);
        checks++;
        if (fifo_cnt !== 3'd1 || word_out !== 16'h6655)
            $display("FAIL resync_word: cnt=%0d out=%h, required 1 6655", fifo_cnt, word_out);
        else passed++;
        pop_one();
        checks++;
        if (word_vld !== 1'b0) $display("FAIL resync_drain: vld=%0b, required 0", word_vld);
        else passed++;
    endtask

    task automatic test_overflow();
        word_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b0);
            send_byte(8'h00, 1'b0);
        end
        checks++;
        if (fifo_cnt !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_full: cnt=%0d ovf=%0b, required 4 1", fifo_cnt, overflow);
        else passed++;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (word_vld !== 1'b1 || word_out !== 16'(i))
                $display("FAIL ovf_drain%0d: vld=%0b out=%h, required 1 %h", i, word_vld, word_out, 16'(i));
            else passed++;
            pop_one();
        end
        checks++;
        if (word_vld !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_after_drain: vld=%0b ovf=%0b, required 0 1", word_vld, overflow);
        else passed++;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: ovf=%0b, required 0", overflow);
        else passed++;
    endtask

    task automatic test_full_pop();
        logic [15:0] exp_q [4];
        exp_q = '{16'h0022, 16'h0033, 16'h0044, 16'h00FF};
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i * 8'h11), 1'b0);
            send_byte(8'h00, 1'b0);
        end
        send_byte(8'hFF, 1'b0);
        byte_in  = 8'h00;
        byte_vld = 1'b1;
        word_rdy = 1'b1;
        @(posedge clk);
        #1;
        byte_vld = 1'b0;
        word_rdy = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd4 || overflow !== 1'b0 || word_out !== 16'h0022)
            $display("FAIL fullpop_state: cnt=%0d ovf=%0b out=%h, required 4 0 0022",
                     fifo_cnt, overflow, word_out);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_vld !== 1'b1 || word_out !== exp_q[i])
                $display("FAIL fullpop_drain%0d: vld=%0b out=%h, required 1 %h", i, word_vld, word_out, exp_q[i]);
            else passed++;
            pop_one();
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'h77, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({word_vld, word_out, fifo_cnt, overflow} !== 21'd0)
            $display("FAIL rstmid_outputs: vld=%0b out=%h cnt=%0d ovf=%0b, required all 0",
                     word_vld, word_out, fifo_cnt, overflow);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h01, 1'b0);
        checks++;
        if (fifo_cnt !== 3'd0) $display("FAIL rstmid_lo: cnt=%0d, required 0", fifo_cnt);
        else passed++;
        send_byte(8'h02, 1'b0);
        checks++;
        if (fifo_cnt !== 3'd1 || word_out !== 16'h0201)
            $display("FAIL rstmid_word: cnt=%0d out=%h, required 1 0201", fifo_cnt, word_out);
        else passed++;
        pop_one();
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        word_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = 16'(i * 16'h0123 + 16'h0A05);
            byte_in = w[7:0];
            byte_vld = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (fifo_cnt > 3'd1 || overflow !== 1'b0)
                $display("FAIL b2b_lo%0d: cnt=%0d ovf=%0b, required <=1 0", i, fifo_cnt, overflow);
            else passed++;
            byte_in = w[15:8];
            @(posedge clk);
            #1;
            checks++;
            if (word_vld !== 1'b1 || word_out !== w || fifo_cnt !== 3'd1 || overflow !== 1'b0)
                $display("FAIL b2b_word%0d: vld=%0b out=%h cnt=%0d ovf=%0b, required 1 %h 1 0",
                         i, word_vld, word_out, fifo_cnt, overflow, w);
            else passed++;
        end
        byte_vld = 1'b0;
        @(posedge clk);
        #1;
        word_rdy = 1'b0;
        checks++;
        if (word_vld !== 1'b0 || fifo_cnt !== 3'd0)
            $display("FAIL b2b_end: vld=%0b cnt=%0d, required 0 0", word_vld, fifo_cnt);
        else passed++;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        rst_n     = 1'b1;
        byte_in   = 8'h00;
        byte_vld  = 1'b0;
        byte_sync = 1'b0;
        word_rdy  = 1'b0;
        clr_ovf   = 1'b0;
        #3;
        test_reset();
        test_basic();
        test_resync();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fir_result_capture.md
# fir_result_capture

Receive-side counterpart of the FIR tile's split output bus. The FIR core writes each 16-bit result as two bytes (low byte first, then high byte); this block samples that byte stream, reassembles 16-bit words, and holds them in a small FIFO. A downstream consumer drains the FIFO through a valid/ready handshake. Used in the on-chip loopback/self-check path and in the board-side capture logic.

## Interface
- `DATA_W`, 16, reassembled word width; always 2×`BYTE_W`.
- `BYTE_W`, 8, input byte width.
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `byte_in`  in  `BYTE_W`  incoming byte.
- `byte_vld`  in  1  `byte_in` is valid this cycle.
- `byte_sync`  in  1  qualified by `byte_vld`; marks `byte_in` as a low byte and resynchronises.
- `word_out`  out  `DATA_W`  FIFO head word, {hi, lo}.
- `word_vld`  out  1  FIFO not empty.
- `word_rdy`  in  1  consumer accepts the head word.
- `fifo_cnt`  out  clog2(`DEPTH`)+1  words held.
- `overflow`  out  1  sticky: a complete word was dropped because the FIFO was full.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- FSM states: `S_LO` (expect low byte), `S_HI` (low byte latched, expect high byte).
- `S_LO` + `byte_vld`: latch `byte_in` into `lo_q` → `S_HI`.
- `S_HI` + `byte_vld` + !`byte_sync`: push {`byte_in`, `lo_q`} → `S_LO`.
- `S_HI` + `byte_vld` + `byte_sync`: discard partial word, latch `byte_in` as the new `lo_q`, stay in `S_HI`.
- `byte_sync` in `S_LO` behaves as a normal low byte.
- No `byte_vld`: state and `lo_q` hold; no timeout.
- Pop: `word_vld && word_rdy` removes the head.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and `fifo_cnt` is unchanged.
  - Otherwise the word is dropped, FIFO contents are untouched, and `overflow` is set.
- Pop when empty: ignored (`word_vld` = 0).
- Push and pop in the same cycle when not full and not empty: both happen; count unchanged.
- Push and pop in the same cycle when empty: push only. There is no bypass, so the word is first visible the next cycle.
- `overflow`: set has priority over `clr_ovf` in the same cycle.
- Pointers wrap modulo `DEPTH`. A full FIFO is distinguished from an empty one by `fifo_cnt`.

## Timing
- Reset values: FSM = `S_LO`, `lo_q` = 0, pointers = 0, `fifo_cnt` = 0, `word_vld` = 0, `word_out` = 0, `overflow` = 0.
- Reset mid-word discards the latched low byte. Reset with data in the FIFO empties it.
- Latency: the high byte is sampled at edge N; `word_vld`/`word_out` reflect the word after edge N (1 cycle).
- Maximum throughput: one word per 2 cycles in, one word per cycle out.
- `word_out` is driven from registered FIFO storage by the read pointer only; no combinational path from `byte_in`.
- `word_vld` and `fifo_cnt` are registered-state functions only; `word_rdy` does not affect them combinationally.

## Structure
- Package `fir_pkg`: `BYTE_W`, `DATA_W` constants and the capture FSM state enum (`S_LO`, `S_HI`). The same package is shared with the FIR tile wrapper.
- Sub-module `sync_fifo`, parameterised by width and depth, with push/pop/full/empty/count. The top level holds the FSM, `lo_q` and the overflow flag.

## Test plan
- **Basic word:** reset, then bytes 0x34 then 0x12 with `byte_vld` → `word_vld` = 1 one cycle after the second byte, `word_out` = 0x1234, `fifo_cnt` = 1. Then `word_rdy` = 1 → `word_vld` = 0.
- **Resync:** bytes 0xAA, then 0x55 with `byte_sync`, then 0x66 → exactly one word, 0x6655; 0xAA is lost.
- **Fill and overflow:** `word_rdy` = 0, push 5 words 0x0001 to 0x0005 → `fifo_cnt` = 4 and `overflow` = 1. Drain yields 0x0001 to 0x0004 in order. `clr_ovf` then clears `overflow`.
- **Full with simultaneous pop:** FIFO full, high byte of 0x00FF arrives while `word_rdy` = 1 → no overflow, `fifo_cnt` stays 4, and 0x00FF appears last on drain.
- **Reset mid-word:** low byte 0x77, assert `rst_n` = 0 for 1 cycle, then bytes 0x01, 0x02 → single word 0x0201 and all outputs at reset values during reset.
- **Back-to-back streaming:** continuous bytes with `word_rdy` = 1 for 16 words → every word matches in order, `overflow` stays 0, and `fifo_cnt` never exceeds 1.
